spart_bus_ctrl: RTL and testbench
=================================

// Module: spart_bus_ctrl
// PURPOSE
//  Bus-side controller for the serial port. Owns the programmable baud divisor and generates
//  the 16x oversample enable that paces the bit receiver (its r_enable) and the transmitter.
//  Buffers each received byte with a ready flag and issues single-cycle start pulses to the
//  transmitter. Exposes a 4-register processor interface: data, status, divisor low, divisor high.
// PARAMETERS
//  DIV_RESET  16'd162  baud divisor after reset; baud_en period = DIV_RESET+1 clk cycles
//  DATA_W     8        serial byte width
// PORTS
//  clk        in   1       system clock; all state on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  iocs       in   1       chip select; no register access when 0
//  iorw       in   1       1 = read, 0 = write; sampled with iocs
//  ioaddr     in   2       00 data, 01 status, 10 DB low, 11 DB high
//  wdata      in   DATA_W  write data from processor
//  rdata      out  DATA_W  registered read data, valid the cycle after a read access
//  baud_en    out  1       16x oversample tick, one clk wide; drives receiver r_enable
//  rx_data    in   DATA_W  byte from the receiver
//  rx_valid   in   1       one-cycle pulse: rx_data holds a complete byte
//  tx_busy    in   1       transmitter shifting a byte
//  tx_data    out  DATA_W  byte to transmit; held stable while tx_busy is 1
//  tx_start   out  1       one-cycle pulse starting a transmission
//  rda        out  1       received byte waiting in the buffer
//  tbr        out  1       transmit buffer ready = !tx_busy && !tx_start
// BEHAVIOUR
//  Reset (async assert, sync deassert at the next posedge): divisor=DIV_RESET, counter=DIV_RESET,
//   rdata=0, rx_buf=0, tx_data=0, baud_en=0, tx_start=0, rda=0, rx_ovr=0, tx_drop=0.
//  Baud: down-counter. When it reaches 0 -> baud_en=1 for 1 cycle, reload from divisor.
//   Divisor 0 -> baud_en held 1 every cycle. A write to DB low updates divisor[7:0] only.
//   A write to DB high updates divisor[15:8] and reloads the counter with the new full divisor
//   in the same cycle, so the first tick comes divisor+1 cycles later.
//  Access = iocs && posedge clk. Reads return in rdata 1 cycle later, and rdata holds until
//   the next read. Read values: 00 rx_buf; 01 {4'b0, rx_ovr, tx_drop, tbr, rda}; 10/11 divisor bytes.
//  Rx: rx_valid -> rx_buf<=rx_data, rda<=1. If rx_valid and rda=1 and no data read in the same
//   cycle -> rx_ovr<=1 and the new byte overwrites. A read of 00 clears rda.
//   rx_valid and a read of 00 in the same cycle -> old byte returned, new byte latched,
//   rda stays 1, no overrun.
//  Tx: a write to 00 with tbr=1 -> tx_data<=wdata, tx_start=1 next cycle (exactly 1 cycle).
//   A write to 00 with tbr=0 -> write discarded, tx_drop<=1.
//  A status read returns the current sticky bits, then clears rx_ovr and tx_drop. A sticky
//   set in the same cycle as the clear wins (the bit stays 1).
//  Writes to 01 are ignored. Reads have no side effects except on 00 and 01.
//  Reset mid-transfer drops the pending tx_start and the buffered byte. The receiver and
//   transmitter reset separately.
// STRUCTURE
//  Shared package: register address localparams (ADDR_DATA, ADDR_STAT, ADDR_DBL, ADDR_DBH),
//   status bit indices, DIV_W=16.
//  One natural sub-module: spart_baud_gen (divisor regs, down-counter, baud_en; load strobes
//   in). The register decode and rx/tx buffers stay in this module.
// TESTING
//  Reset, idle 500 cycles -> baud_en period = 163 cycles exactly; rda=0, tbr=1, rdata=0.
//  Write DBL=0x0A, then DBH=0x00 -> next baud_en 11 cycles after the DBH write, period 11 after.
//   Write DBH=0x00, then DBL=0x00 -> baud_en every cycle.
//  rx_valid with 0x5A -> rda=1. Read 00 -> rdata=0x5A the next cycle, rda=0. A second
//   rx_valid before the read -> status=0x09, and status reads 0x01 after the clear.
//  rx_valid with 0x33 and read 00 in the same cycle, rx_buf holding 0x11 -> rdata=0x11,
//   rda=1, rx_ovr=0. The next read returns 0x33.
//  Write 00=0xC3 with tx_busy=0 -> tx_start 1 cycle, tx_data=0xC3. Write 00 with tx_busy=1
//   -> no tx_start, status bit2=1, cleared by the status read.
//  Assert rst_n low mid-cycle while rda=1 and a tx_start is pending -> all outputs return to
//   reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/spart_bus_ctrl_pkg.sv
// Shared definitions for the serial-port bus controller: register map, status bit
// positions and the processor-access decode helper.
package spart_bus_ctrl_pkg;

    localparam int DIV_W = 16;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int STAT_RDA  = 0;
    localparam int STAT_TBR  = 1;
    localparam int STAT_DROP = 2;
    localparam int STAT_OVR  = 3;

    typedef struct packed {
        logic rd;
        logic rd_data;
        logic rd_stat;
        logic wr_data;
        logic wr_dbl;
        logic wr_dbh;
    } bus_dec_t;

    // Writes to the status address decode to nothing, so they are silently ignored.
    function automatic bus_dec_t bus_decode(input logic iocs, input logic iorw,
                                            input logic [1:0] addr);
        bus_dec_t d;
        d = '{default: 1'b0};
        d.rd = iocs & iorw;
        if (iocs) begin
            case (addr)
                ADDR_DATA: begin
                    d.rd_data = iorw;
                    d.wr_data = ~iorw;
                end
                ADDR_STAT: d.rd_stat = iorw;
                ADDR_DBL:  d.wr_dbl  = ~iorw;
                ADDR_DBH:  d.wr_dbh  = ~iorw;
                default:   d = '{default: 1'b0};
            endcase
        end else begin
            d = '{default: 1'b0};
        end
        return d;
    endfunction

endpackage

// File: rtl/spart_bus_ctrl_if.sv
// Processor-side register bus of the serial port: select, direction, address,
// write data and the registered read data returned by the controller.
interface spart_bus_ctrl_if #(parameter int DATA_W = 8);
    logic              iocs;
    logic              iorw;
    logic [1:0]        ioaddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output iocs, output iorw, output ioaddr, output wdata, input rdata);
    modport slave  (input iocs, input iorw, input ioaddr, input wdata, output rdata);
endinterface

// File: rtl/spart_baud_gen.sv
// Programmable baud divisor and down-counter producing the one-clock 16x oversample tick.
module spart_baud_gen
    import spart_bus_ctrl_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd162
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_lo,
    input  logic             ld_hi,
    input  logic [7:0]       wdata,
    output logic [DIV_W-1:0] divisor,
    output logic             baud_en
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             baud_en_q, baud_en_d;
    logic [DIV_W-1:0] new_div_s;

    // Next divisor/counter; a high-byte load restarts the period so the first tick is divisor+1 away.
    always_comb begin
        div_d     = div_q;
        cnt_d     = cnt_q;
        baud_en_d = 1'b0;
        new_div_s = {wdata, div_q[7:0]};
        if (ld_hi) begin
            div_d     = new_div_s;
            cnt_d     = new_div_s;
            baud_en_d = 1'b0;
        end else begin
            if (ld_lo) begin
                div_d = {div_q[DIV_W-1:8], wdata};
            end else begin
                div_d = div_q;
            end
            if (cnt_q == 16'd0) begin
                cnt_d     = div_q;
                baud_en_d = 1'b1;
            end else begin
                cnt_d     = cnt_q - 16'd1;
                baud_en_d = 1'b0;
            end
        end
    end

    // Divisor, counter and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= DIV_RESET;
            cnt_q     <= DIV_RESET;
            baud_en_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            baud_en_q <= baud_en_d;
        end
    end

    assign divisor = div_q;
    assign baud_en = baud_en_q;

endmodule

// File: rtl/spart_bus_ctrl.sv
// Bus-side serial-port controller: register decode, receive byte buffer with sticky
// overrun, transmit start pulses with sticky drop, and the baud generator.
module spart_bus_ctrl
    import spart_bus_ctrl_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd162,
    parameter int               DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spart_bus_ctrl_if.slave   bus,
    output logic              baud_en,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    output logic              rda,
    output logic              tbr
);

    bus_dec_t          dec_s;
    logic              tbr_s;
    logic [DATA_W-1:0] status_s;
    logic [DIV_W-1:0]  divisor_s;

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] rx_buf_q, rx_buf_d;
    logic              rda_q, rda_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              tx_drop_q, tx_drop_d;

    spart_baud_gen #(.DIV_RESET(DIV_RESET)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_lo   (dec_s.wr_dbl),
        .ld_hi   (dec_s.wr_dbh),
        .wdata   (bus.wdata[7:0]),
        .divisor (divisor_s),
        .baud_en (baud_en)
    );

    // Decode, read mux and buffer next-state; sticky sets take priority over the status-read clear.
    always_comb begin
        dec_s    = bus_decode(bus.iocs, bus.iorw, bus.ioaddr);
        tbr_s    = ~tx_busy & ~tx_start_q;
        status_s = {DATA_W{1'b0}};
        status_s[STAT_RDA]  = rda_q;
        status_s[STAT_TBR]  = tbr_s;
        status_s[STAT_DROP] = tx_drop_q;
        status_s[STAT_OVR]  = rx_ovr_q;

        rdata_d = rdata_q;
        if (dec_s.rd) begin
            case (bus.ioaddr)
                ADDR_DATA: rdata_d = rx_buf_q;
                ADDR_STAT: rdata_d = status_s;
                ADDR_DBL:  rdata_d = DATA_W'(divisor_s[7:0]);
                ADDR_DBH:  rdata_d = DATA_W'(divisor_s[15:8]);
                default:   rdata_d = rdata_q;
            endcase
        end else begin
            rdata_d = rdata_q;
        end

        if (rx_valid) begin
            rx_buf_d = rx_data;
            rda_d    = 1'b1;
        end else if (dec_s.rd_data) begin
            rx_buf_d = rx_buf_q;
            rda_d    = 1'b0;
        end else begin
            rx_buf_d = rx_buf_q;
            rda_d    = rda_q;
        end

        if (rx_valid && rda_q && !dec_s.rd_data) begin
            rx_ovr_d = 1'b1;
        end else if (dec_s.rd_stat) begin
            rx_ovr_d = 1'b0;
        end else begin
            rx_ovr_d = rx_ovr_q;
        end

        if (dec_s.wr_data && tbr_s) begin
            tx_data_d  = bus.wdata;
            tx_start_d = 1'b1;
        end else begin
            tx_data_d  = tx_data_q;
            tx_start_d = 1'b0;
        end

        if (dec_s.wr_data && !tbr_s) begin
            tx_drop_d = 1'b1;
        end else if (dec_s.rd_stat) begin
            tx_drop_d = 1'b0;
        end else begin
            tx_drop_d = tx_drop_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= {DATA_W{1'b0}};
            rx_buf_q   <= {DATA_W{1'b0}};
            rda_q      <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_data_q  <= {DATA_W{1'b0}};
            tx_start_q <= 1'b0;
            tx_drop_q  <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tx_drop_q  <= tx_drop_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign rda       = rda_q;
    assign tbr       = ~tx_busy & ~tx_start_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Scoreboard bench for spart_bus_ctrl: directed register/rx/tx/baud vectors with
// expected read data and transmit bytes queued and checked by a separate monitor.
module tb_spart_bus_ctrl;

    logic       clk;
    logic       rst_n;
    logic       baud_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       rda;
    logic       tbr;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_rd[$];
    logic [7:0] exp_tx[$];
    logic       rd_seen;

    spart_bus_ctrl_if #(.DATA_W(8)) bus ();

    spart_bus_ctrl #(.DIV_RESET(16'd162), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .baud_en  (baud_en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .rda      (rda),
        .tbr      (tbr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp);
        exp_rd.push_back(exp);
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b1;
        bus.ioaddr = a;
        cycle();
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = a;
        bus.wdata  = d;
        cycle();
        bus.iocs   = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        cycle();
        rx_valid = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (baud_en !== 1'b1 && n < 2000);
    endtask

    // Monitor: a read accepted at a posedge is checked on the following negedge,
    // and every tx_start pulse must match a queued transmit byte.
    initial begin
        forever begin
            @(posedge clk);
            rd_seen = rst_n && bus.iocs && bus.iorw;
            @(negedge clk);
            if (rd_seen) begin
                check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) check("rdata", bus.rdata, exp_rd.pop_front());
            end
            if (tx_start === 1'b1) begin
                check("tx_start_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) check("tx_data", tx_data, exp_tx.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ones;
        rst_n      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        tx_busy    = 1'b0;
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b00;
        bus.wdata  = 8'h00;
        repeat (3) cycle();
        check("reset_rda", rda, 1'b0);
        check("reset_tbr", tbr, 1'b1);
        check("reset_rdata", bus.rdata, 8'h00);
        check("reset_baud_en", baud_en, 1'b0);
        check("reset_tx_start", tx_start, 1'b0);
        check("reset_tx_data", tx_data, 8'h00);
        rst_n = 1'b1;

        // Reset divisor 162: first tick and every period after are 163 cycles.
        wait_tick(n); check("baud_first", n, 163);
        wait_tick(n); check("baud_period1", n, 163);
        wait_tick(n); check("baud_period2", n, 163);
        check("idle_rda", rda, 1'b0);
        check("idle_tbr", tbr, 1'b1);
        check("idle_rdata", bus.rdata, 8'h00);

        wr(2'b10, 8'h0A);
        wr(2'b11, 8'h00);
        wait_tick(n); check("baud_after_dbh", n, 11);
        wait_tick(n); check("baud_period10", n, 11);
        rd(2'b10, 8'h0A);
        rd(2'b11, 8'h00);

        wr(2'b11, 8'h00);
        wr(2'b10, 8'h00);
        repeat (12) cycle();
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (baud_en === 1'b1) ones++;
            cycle();
        end
        check("baud_div0_every_cycle", ones, 8);

        rx_pulse(8'h5A);
        check("rx_rda_set", rda, 1'b1);
        rd(2'b00, 8'h5A);
        check("rx_rda_clear", rda, 1'b0);

        // Transmitter held busy here, so tbr reads 0 in these status values.
        tx_busy = 1'b1;
        rx_pulse(8'h21);
        rx_pulse(8'h22);
        rd(2'b01, 8'h09);
        rd(2'b01, 8'h01);
        rd(2'b00, 8'h22);
        tx_busy = 1'b0;

        rx_pulse(8'h11);
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        rd(2'b00, 8'h11);
        rx_valid = 1'b0;
        check("same_cycle_rda", rda, 1'b1);
        rd(2'b01, 8'h03);
        rd(2'b00, 8'h33);

        exp_tx.push_back(8'hC3);
        wr(2'b00, 8'hC3);
        check("tx_start_high", tx_start, 1'b1);
        check("tbr_during_start", tbr, 1'b0);
        cycle();
        check("tx_start_one_cycle", tx_start, 1'b0);
        tx_busy = 1'b1;
        wr(2'b00, 8'h77);
        check("tx_data_held", tx_data, 8'hC3);
        rd(2'b01, 8'h04);
        rd(2'b01, 8'h00);
        tx_busy = 1'b0;

        rx_pulse(8'h44);
        rx_valid = 1'b1;
        rx_data  = 8'h45;
        rd(2'b01, 8'h03);
        rx_valid = 1'b0;
        rd(2'b01, 8'h0B);
        rd(2'b00, 8'h45);

        // Asynchronous reset between edges with a byte buffered and a start pulse in flight.
        rx_pulse(8'h99);
        wr(2'b00, 8'h5C);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rda", rda, 1'b0);
        check("async_tx_start", tx_start, 1'b0);
        check("async_tbr", tbr, 1'b1);
        check("async_tx_data", tx_data, 8'h00);
        check("async_rdata", bus.rdata, 8'h00);
        check("async_baud_en", baud_en, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b1;
        rd(2'b10, 8'hA2);
        rd(2'b11, 8'h00);
        rd(2'b01, 8'h02);
        rd(2'b00, 8'h00);
        repeat (3) cycle();
        check("rd_queue_drained", exp_rd.size(), 0);
        check("tx_queue_drained", exp_tx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
